// File: rtl/stack_pkg.sv
// Shared definitions for the memory-backed stack master: op encodings,
// controller states and the default stack window.
package stack_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] STACK_LO_DEF = 5'd16;
    localparam logic [ADDR_W-1:0] STACK_HI_DEF = 5'd23;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_RESP
    } state_t;

endpackage

// File: rtl/stack_mem_master.sv
// Downward-growing stack kept in an external single-port memory; serves one
// PUSH/POP/PEEK request at a time with clean, non-overlapping strobes.
module stack_mem_master
    import stack_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_LO = STACK_LO_DEF,
    parameter logic [ADDR_W-1:0] STACK_HI = STACK_HI_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [CNT_W-1:0]  count,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);

    localparam int unsigned      DEPTH   = 32'(STACK_HI) - 32'(STACK_LO) + 32'd1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] sp;
    logic [1:0]        op_q;
    logic              accept;

    assign accept = (state == S_IDLE) && req_valid;

    // Next-state: errors short-circuit straight to the response cycle
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (req_op)
                        OP_PUSH:         state_n = (count < DEPTH_C) ? S_WR  : S_RESP;
                        OP_POP, OP_PEEK: state_n = (count != '0)     ? S_RD1 : S_RESP;
                        default:         state_n = S_RESP;
                    endcase
                end
            end
            S_WR:    state_n = S_RESP;
            S_RD1:   state_n = S_RD2;
            S_RD2:   state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // All outputs registered from the next state so strobes are glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sp         <= STACK_HI;
            count      <= '0;
            op_q       <= OP_PUSH;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            address    <= '0;
            writeData  <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == S_IDLE);
            resp_valid <= (state_n == S_RESP);
            memwrite   <= (state_n == S_WR);
            memread    <= (state_n == S_RD1) || (state_n == S_RD2);

            if (accept) begin
                op_q <= req_op;
            end
            // Address/data only move on the edge where a strobe rises
            if (accept && (state_n == S_WR)) begin
                address   <= sp;
                writeData <= req_data;
            end
            if (accept && (state_n == S_RD1)) begin
                address <= sp + 5'd1;
            end
            if (accept && (state_n == S_RESP)) begin
                resp_err  <= 1'b1;
                resp_data <= '0;
            end

            if (state == S_WR) begin
                sp        <= sp - 5'd1;
                count     <= count + 4'd1;
                resp_err  <= 1'b0;
                resp_data <= '0;
            end
            if (state == S_RD2) begin
                resp_data <= readData;
                resp_err  <= 1'b0;
                if (op_q == OP_POP) begin
                    sp    <= sp + 5'd1;
                    count <= count - 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/stack_mem_master.md
STACK_MEM_MASTER -- requirements
Module: stack_mem_master

Interface
REQ-001 Parameter STACK_LO, default 5'd16, lowest stack address.
REQ-002 Parameter STACK_HI, default 5'd23, highest stack address; the stack grows downward from it; DEPTH = STACK_HI-STACK_LO+1.
REQ-003 The block SHALL use one clock, clk; reset is rst, asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 reserved (treated as error).
REQ-008 req_data  input  8  PUSH operand.
REQ-009 req_ready  output  1  high only in IDLE.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_data  output  8  POP/PEEK result; 0 for PUSH and errors.
REQ-012 resp_err  output  1  qualifies resp_valid: overflow, underflow or reserved op.
REQ-013 count  output  4  current occupancy, 0..DEPTH.
REQ-014 memread, memwrite  output  1 each  memory strobes.
REQ-015 address  output  5; writeData  output  8; readData  input  8.

Function
REQ-016 Accept when req_valid && req_ready at a rising edge; operands latched at acceptance.
REQ-017 sp (5-bit) SHALL hold the next free address; empty when count==0 (sp==STACK_HI); full when count==DEPTH (sp==STACK_LO-1).
REQ-018 States: IDLE, WR, RD1, RD2, RESP.
REQ-019 IDLE->WR on accepted PUSH with count<DEPTH; WR asserts memwrite=1, address=sp, writeData=operand for exactly one cycle.
REQ-020 IDLE->RD1 on accepted POP/PEEK with count>0; RD1 and RD2 assert memread=1, address=sp+1; readData latched at the end of RD2.
REQ-021 IDLE->RESP directly on PUSH when full, POP/PEEK when empty, or reserved op; no strobe asserted; resp_err=1.
REQ-022 RESP asserts resp_valid for one cycle, then returns to IDLE; sp/count update in the WR->RESP (PUSH: sp-1, count+1) or RD2->RESP (POP: sp+1, count-1) transition; PEEK leaves both unchanged.
REQ-023 Latency acceptance-edge to resp_valid: PUSH 2 cycles, POP/PEEK 3 cycles, error 1 cycle.
REQ-024 memread and memwrite SHALL never be high together, and SHALL both be low in IDLE and RESP so every access produces a fresh strobe edge.
REQ-025 address and writeData SHALL only change while both strobes are low or on the cycle a strobe rises; they hold steady while a strobe is high.
REQ-026 Addresses outside STACK_LO..STACK_HI SHALL never be driven with a strobe high.
REQ-027 req_valid while not in IDLE is ignored (req_ready=0); the request is not queued.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, sp=STACK_HI, count=0, memread=0, memwrite=0, address=0, writeData=0, resp_valid=0, resp_data=0, resp_err=0.
REQ-029 Reset mid-operation aborts the access without a response; a PUSH aborted in WR leaves the memory contents undefined at that address but the stack empty.

Structure
REQ-030 Shared package stack_pkg SHALL hold op encodings, the state enumeration and default STACK_LO/STACK_HI.
REQ-031 Single flat module; no sub-module required.

Verification
REQ-032 Reset, then PUSH 8'd57 -> memwrite high one cycle at address 23, resp_valid at acceptance+2, resp_err=0, count=1.
REQ-033 PUSH 57, PUSH 79, POP, POP -> second PUSH writes address 22; POPs read addresses 22 then 23, returning 79 then 57; count returns to 0.
REQ-034 POP on empty -> resp_valid at acceptance+1 with resp_err=1, resp_data=0, no strobe, count stays 0.
REQ-035 Eight PUSHes (1..8), then a ninth PUSH -> the ninth gets resp_err=1 with no memwrite; count=8; PEEK returns 8 with count unchanged.
REQ-036 Assert rst while in RD1 -> strobes drop asynchronously, no resp_valid, count=0; the next PUSH writes address 23.
REQ-037 req_op=11 -> resp_err=1 at acceptance+1; assertion check throughout: memread&&memwrite never true.
